// File: rtl/control_pkg.sv
// Shared definitions for the CPU control unit: opcodes, ALU selects,
// FSM states and the packed control word.
package control_pkg;

    localparam logic [7:0] OP_LOADI = 8'h00;
    localparam logic [7:0] OP_MOV   = 8'h01;
    localparam logic [7:0] OP_ADD   = 8'h02;
    localparam logic [7:0] OP_SUB   = 8'h03;
    localparam logic [7:0] OP_AND   = 8'h04;
    localparam logic [7:0] OP_OR    = 8'h05;
    localparam logic [7:0] OP_J     = 8'h06;
    localparam logic [7:0] OP_BEQ   = 8'h07;
    localparam logic [7:0] OP_LWD   = 8'h08;
    localparam logic [7:0] OP_LWI   = 8'h09;
    localparam logic [7:0] OP_SWD   = 8'h0A;
    localparam logic [7:0] OP_SWI   = 8'h0B;
    localparam logic [7:0] OP_MULT  = 8'h0C;
    localparam logic [7:0] OP_SLL   = 8'h0D;
    localparam logic [7:0] OP_SRL   = 8'h0E;
    localparam logic [7:0] OP_SRA   = 8'h0F;
    localparam logic [7:0] OP_BNE   = 8'h10;

    typedef enum logic [2:0] {
        ALU_FWD  = 3'b000,
        ALU_ADD  = 3'b001,
        ALU_AND  = 3'b010,
        ALU_OR   = 3'b011,
        ALU_MULT = 3'b100,
        ALU_SLL  = 3'b101,
        ALU_SRL  = 3'b110,
        ALU_SRA  = 3'b111
    } aluop_e;

    typedef enum logic [1:0] {
        IDLE,
        MEM,
        WB,
        ERR
    } state_e;

    typedef struct packed {
        logic   we;
        aluop_e aluop;
        logic   comp;
        logic   imm;
        logic   branch;
        logic   bne;
        logic   jump;
        logic   read;
        logic   write;
        logic   load_word;
    } ctrl_t;

    function automatic logic is_mem(input ctrl_t c);
        return c.read | c.write;
    endfunction

endpackage

// File: rtl/control_fsm_if.sv
// Instruction handshake, data-memory status and control-word outputs
// of the control unit.
interface control_fsm_if #(
    parameter int INSTR_W = 32,
    parameter int ALUOP_W = 3
);
    logic [INSTR_W-1:0] INSTRUCTION;
    logic               INSTR_VALID;
    logic               BUSYWAIT;
    logic               READY;
    logic               WRITEENABLE;
    logic [ALUOP_W-1:0] ALUOP;
    logic               COMPLEMENT_FLAG;
    logic               IMMEDIATE_FLAG;
    logic               BRANCH_FLAG;
    logic               BNE_FLAG;
    logic               JUMP_FLAG;
    logic               READ;
    logic               WRITE;
    logic               LOAD_WORD_FLAG;
    logic               PC_STALL;
    logic               ILLEGAL_OP;
    logic               MEM_ERROR;

    modport master (
        output INSTRUCTION, INSTR_VALID, BUSYWAIT,
        input  READY, WRITEENABLE, ALUOP, COMPLEMENT_FLAG,
        input  IMMEDIATE_FLAG, BRANCH_FLAG, BNE_FLAG, JUMP_FLAG,
        input  READ, WRITE, LOAD_WORD_FLAG, PC_STALL,
        input  ILLEGAL_OP, MEM_ERROR
    );

    modport slave (
        input  INSTRUCTION, INSTR_VALID, BUSYWAIT,
        output READY, WRITEENABLE, ALUOP, COMPLEMENT_FLAG,
        output IMMEDIATE_FLAG, BRANCH_FLAG, BNE_FLAG, JUMP_FLAG,
        output READ, WRITE, LOAD_WORD_FLAG, PC_STALL,
        output ILLEGAL_OP, MEM_ERROR
    );
endinterface

// File: rtl/control_decode.sv
// Combinational opcode decoder: opcode to control word, with an
// illegal flag and an all-zero word for undefined opcodes.
module control_decode
    import control_pkg::*;
#(
    parameter int OPCODE_W = 8
) (
    input  logic [OPCODE_W-1:0] opcode_i,
    output ctrl_t               ctrl_o,
    output logic                illegal_o
);

    always_comb begin
        ctrl_o    = '0;
        illegal_o = 1'b0;
        unique case (opcode_i)
            OPCODE_W'(OP_LOADI): begin ctrl_o.we = 1'b1; ctrl_o.imm = 1'b1; end
            OPCODE_W'(OP_MOV):   ctrl_o.we = 1'b1;
            OPCODE_W'(OP_ADD):   begin ctrl_o.we = 1'b1; ctrl_o.aluop = ALU_ADD; end
            OPCODE_W'(OP_SUB): begin
                ctrl_o.we    = 1'b1;
                ctrl_o.comp  = 1'b1;
                ctrl_o.aluop = ALU_ADD;
            end
            OPCODE_W'(OP_AND):   begin ctrl_o.we = 1'b1; ctrl_o.aluop = ALU_AND; end
            OPCODE_W'(OP_OR):    begin ctrl_o.we = 1'b1; ctrl_o.aluop = ALU_OR; end
            OPCODE_W'(OP_MULT):  begin ctrl_o.we = 1'b1; ctrl_o.aluop = ALU_MULT; end
            OPCODE_W'(OP_SLL): begin
                ctrl_o.we = 1'b1; ctrl_o.imm = 1'b1; ctrl_o.aluop = ALU_SLL;
            end
            OPCODE_W'(OP_SRL): begin
                ctrl_o.we = 1'b1; ctrl_o.imm = 1'b1; ctrl_o.aluop = ALU_SRL;
            end
            OPCODE_W'(OP_SRA): begin
                ctrl_o.we = 1'b1; ctrl_o.imm = 1'b1; ctrl_o.aluop = ALU_SRA;
            end
            OPCODE_W'(OP_BEQ): begin
                ctrl_o.comp = 1'b1; ctrl_o.aluop = ALU_ADD; ctrl_o.branch = 1'b1;
            end
            OPCODE_W'(OP_BNE): begin
                ctrl_o.comp = 1'b1; ctrl_o.aluop = ALU_ADD; ctrl_o.bne = 1'b1;
            end
            OPCODE_W'(OP_J):     ctrl_o.jump = 1'b1;
            OPCODE_W'(OP_LWD):   begin ctrl_o.read = 1'b1; ctrl_o.load_word = 1'b1; end
            OPCODE_W'(OP_LWI): begin
                ctrl_o.read = 1'b1; ctrl_o.load_word = 1'b1; ctrl_o.imm = 1'b1;
            end
            OPCODE_W'(OP_SWD):   ctrl_o.write = 1'b1;
            OPCODE_W'(OP_SWI):   begin ctrl_o.write = 1'b1; ctrl_o.imm = 1'b1; end
            default:             illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/control_fsm.sv
// Registered multi-cycle control unit: one-cycle decode for ALU/branch
// ops, MEM/WB sequencing with stall and optional timeout for loads/stores.
module control_fsm
    import control_pkg::*;
#(
    parameter int INSTR_W     = 32,
    parameter int OPCODE_W    = 8,
    parameter int ALUOP_W     = 3,
    parameter int MEM_TIMEOUT = 256
) (
    input logic         CLK,
    input logic         RESET,
    control_fsm_if.slave bus
);

    localparam int CNT_W = (MEM_TIMEOUT < 3) ? 2 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX =
        (MEM_TIMEOUT == 0) ? {CNT_W{1'b1}} : CNT_W'(MEM_TIMEOUT);

    state_e           state_q, state_d;
    ctrl_t            ctrl_q, ctrl_d;
    logic             stall_q, stall_d;
    logic             ill_q, ill_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    ctrl_t            dec_ctrl;
    logic             dec_ill;

    control_decode #(
        .OPCODE_W(OPCODE_W)
    ) u_decode (
        .opcode_i (bus.INSTRUCTION[INSTR_W-1 -: OPCODE_W]),
        .ctrl_o   (dec_ctrl),
        .illegal_o(dec_ill)
    );

    always_comb begin
        state_d = state_q;
        ctrl_d  = '0;
        stall_d = 1'b0;
        ill_d   = 1'b0;
        err_d   = err_q;
        cnt_d   = '0;
        unique case (state_q)
            IDLE: begin
                if (bus.INSTR_VALID) begin
                    ctrl_d = dec_ctrl;
                    ill_d  = dec_ill;
                    if (is_mem(dec_ctrl)) begin
                        state_d = MEM;
                        stall_d = 1'b1;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            MEM: begin
                ctrl_d  = ctrl_q;
                stall_d = 1'b1;
                cnt_d   = cnt_q;
                // The first MEM cycle never completes, even if BUSYWAIT is low
                if (!bus.BUSYWAIT && cnt_q >= CNT_W'(2)) begin
                    cnt_d = '0;
                    if (ctrl_q.read) begin
                        state_d      = WB;
                        ctrl_d.read  = 1'b0;
                        ctrl_d.write = 1'b0;
                        ctrl_d.we    = 1'b1;
                    end else begin
                        state_d = IDLE;
                        ctrl_d  = '0;
                        stall_d = 1'b0;
                    end
                end else if (MEM_TIMEOUT != 0 && bus.BUSYWAIT
                             && cnt_q >= CNT_MAX) begin
                    state_d = ERR;
                    ctrl_d  = '0;
                    err_d   = 1'b1;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WB: state_d = IDLE;
            ERR: stall_d = 1'b1;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            ctrl_q  <= '0;
            stall_q <= 1'b0;
            ill_q   <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
            stall_q <= stall_d;
            ill_q   <= ill_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.READY           = (state_q == IDLE);
    assign bus.WRITEENABLE     = ctrl_q.we;
    assign bus.ALUOP           = ALUOP_W'(ctrl_q.aluop);
    assign bus.COMPLEMENT_FLAG = ctrl_q.comp;
    assign bus.IMMEDIATE_FLAG  = ctrl_q.imm;
    assign bus.BRANCH_FLAG     = ctrl_q.branch;
    assign bus.BNE_FLAG        = ctrl_q.bne;
    assign bus.JUMP_FLAG       = ctrl_q.jump;
    assign bus.READ            = ctrl_q.read;
    assign bus.WRITE           = ctrl_q.write;
    assign bus.LOAD_WORD_FLAG  = ctrl_q.load_word;
    assign bus.PC_STALL        = stall_q;
    assign bus.ILLEGAL_OP      = ill_q;
    assign bus.MEM_ERROR       = err_q;

endmodule
